mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter VEC_LEN, default 784, number of int8 product terms per dot product (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port bias_in, input, signed 32, bias added once per dot product.
REQ-005 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-006 SHALL have port in_ready, output, 1, beat accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port act_in, input, signed 8, activation operand.
REQ-008 SHALL have port wgt_in, input, signed 8, weight operand.
REQ-009 SHALL have port out_valid, output, 1, acc_out holds a completed dot product.
REQ-010 SHALL have port out_ready, input, 1, downstream requantizer accepts acc_out.
REQ-011 SHALL have port acc_out, output, signed 32, completed accumulator value for the int32-to-int8 requantize stage.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, ACCUM and HOLD.
REQ-014 IDLE: in_ready=1; first accepted beat loads acc = bias_in + act_in*wgt_in, sets beat_cnt=1, then goes to ACCUM, or to HOLD if VEC_LEN=1.
REQ-015 ACCUM: in_ready=1; each accepted beat does acc += act_in*wgt_in and beat_cnt += 1; the beat making beat_cnt equal VEC_LEN moves the block to HOLD.
REQ-016 Cycles with in_valid low SHALL leave acc and beat_cnt unchanged (bubbles allowed anywhere).
REQ-017 HOLD: out_valid=1, in_ready=0, acc_out=acc; acc_out stays stable until out_ready=1.
REQ-018 HOLD with out_ready=1 SHALL return to IDLE on the next edge; in_ready rises one cycle after the handshake, with no same-cycle bypass.
REQ-019 Latency: out_valid SHALL assert on the cycle after the edge that accepted the VEC_LEN-th beat.
REQ-020 Product: full 16-bit signed act_in*wgt_in, sign-extended to 32 bits before addition.
REQ-021 Without MAC_SAT_EN, accumulation SHALL wrap as two's complement modulo 2^32.
REQ-022 in_valid asserted during HOLD SHALL be ignored; no beat is consumed.
REQ-023 bias_in SHALL be sampled only on the first accepted beat; later changes have no effect on the current dot product.
REQ-024 beat_cnt SHALL be an internal counter, $clog2(VEC_LEN+1) bits wide, cleared on every entry to IDLE.

Reset
REQ-025 While rst_n=0: state=IDLE, acc=0, beat_cnt=0, out_valid=0, acc_out=0, busy=0; in_ready=1 once rst_n deasserts.
REQ-026 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the partial or pending result; the first beat after release starts a fresh dot product with a new bias.

Configuration
REQ-027 Macro MAC_ACCUMULATOR_SAT_EN defined: every addition SHALL saturate to 0x7FFFFFFF / 0x80000000 instead of wrapping, and once saturated a value changes only when a later term moves it back inside range.
REQ-028 Macro MAC_ACCUMULATOR_SAT_EN undefined: wrap behaviour per REQ-021, with no saturation logic synthesized.

Structure
REQ-029 The shared package SHALL hold ACC_W=32, DATA_W=8, PROD_W=16 and the state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2), all reused by the requantize stage.
REQ-030 One sub-module, mac_sat_add, SHALL implement the 32-bit add that saturates or wraps under the macro; the FSM, counter and handshake stay in mac_accumulator.

Verification
REQ-031 VEC_LEN=4, bias=10, act=[1,2,3,4], wgt=[1,1,1,1], no bubbles -> out_valid on the 5th cycle after the first beat, acc_out=20.
REQ-032 VEC_LEN=2, bias=0, act=[-128,-128], wgt=[-128,127] -> acc_out=16384-16256=128.
REQ-033 VEC_LEN=3, bubbles between every beat, out_ready held 0 for 5 cycles -> acc_out stable and in_ready=0 throughout; in_valid pulses during HOLD not consumed; the next vector is computed correctly.
REQ-034 VEC_LEN=2, bias=0x7FFFFFF0, act=[127,127], wgt=[127,127] -> with macro acc_out=0x7FFFFFFF; without macro acc_out=0x7FFFFFF0+32258 mod 2^32.
REQ-035 rst_n pulsed low after 2 of 4 beats -> out_valid=0, busy=0; the next full vector with bias=0, act=[1,1,1,1], wgt=[2,2,2,2] gives acc_out=8.
REQ-036 VEC_LEN=1, out_ready tied 1 -> one result every 2 cycles, acc_out = bias + product for each beat.

Source files
------------

// File: rtl/mac_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// mac_accumulator_pkg
//   Shared widths and FSM state encoding for the int8 MAC accumulator and the
//   downstream int32-to-int8 requantize stage.
//   ACC_W  : accumulator / bias / result width
//   DATA_W : activation and weight operand width
//   PROD_W : full signed product width (DATA_W * 2)
//   mac_state_e : IDLE=0, ACCUM=1, HOLD=2
// ----------------------------------------------------------------------------
package mac_accumulator_pkg;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mac_sat_add.sv
// ----------------------------------------------------------------------------
// mac_sat_add
//   32-bit signed adder used for every accumulator update.
//   Build option MAC_ACCUMULATOR_SAT_EN:
//     defined   -> result clamps to 0x7FFFFFFF / 0x80000000 on overflow
//     undefined -> plain two's complement wrap, no clamp logic
//   Ports:
//     a_i   : signed ACC_W addend (bias or running accumulator)
//     b_i   : signed ACC_W addend (sign-extended product)
//     sum_o : signed ACC_W result
// ----------------------------------------------------------------------------
module mac_sat_add
    import mac_accumulator_pkg::*;
(
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W-1:0] b_i,
    output logic signed [ACC_W-1:0] sum_o
);

`ifdef MAC_ACCUMULATOR_SAT_EN
    localparam logic [ACC_W-1:0] SatMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SatMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};
        // Top two bits disagree only when the true sum left the ACC_W range.
        if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
            sum_o = wide_sum[ACC_W] ? SatMin : SatMax;
        end else begin
            sum_o = wide_sum[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        sum_o = a_i + b_i;
    end
`endif

endmodule

// File: rtl/mac_accumulator.sv
// ----------------------------------------------------------------------------
// mac_accumulator
//   Streams VEC_LEN signed int8 act*wgt beats, adds a bias once per dot
//   product and presents the 32-bit result to the requantize stage with a
//   valid/ready handshake.
//   Build option MAC_ACCUMULATOR_SAT_EN selects saturating instead of wrapping
//   accumulation (see mac_sat_add).
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     bias_in             : signed 32-bit bias, sampled on the first beat
//     in_valid / in_ready : input beat handshake
//     act_in, wgt_in      : signed 8-bit operands
//     out_valid/out_ready : result handshake
//     acc_out             : completed signed 32-bit dot product
//     busy                : high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int unsigned VEC_LEN = 784
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [ACC_W-1:0]   bias_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  act_in,
    input  logic signed [DATA_W-1:0]  wgt_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   acc_out,
    output logic                      busy
);

    localparam int unsigned       CNT_W   = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0]  LastCnt = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0]  OneCnt  = CNT_W'(1);

    mac_state_e               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  add_a;
    logic signed [ACC_W-1:0]  add_sum;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     accept;

    always_comb begin
        prod     = act_in * wgt_in;
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        // The first beat of a vector starts from the bias, later beats from acc.
        add_a    = (state_q == IDLE) ? bias_in : acc_q;
        cnt_inc  = cnt_q + OneCnt;
    end

    mac_sat_add u_sat_add (
        .a_i   (add_a),
        .b_i   (prod_ext),
        .sum_o (add_sum)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    acc_d   = add_sum;
                    cnt_d   = OneCnt;
                    state_d = (VEC_LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == LastCnt) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        acc_out = acc_q;
        busy    = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

    logic clk;
    logic rst_n;

    // Four DUTs: index 0 VEC_LEN=4, 1 VEC_LEN=2, 2 VEC_LEN=3, 3 VEC_LEN=1.
    logic [3:0]         in_valid;
    logic [3:0]         in_ready;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [3:0]         busy;
    logic signed [7:0]  act     [4];
    logic signed [7:0]  wgt     [4];
    logic signed [31:0] bias    [4];
    logic signed [31:0] acc_out [4];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mac_accumulator #(
            .VEC_LEN ((g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .bias_in   (bias[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .act_in    (act[g]),
            .wgt_in    (wgt[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .acc_out   (acc_out[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat to DUT d and let one edge pass.
    task automatic beat(input int d, input logic signed [7:0] a, input logic signed [7:0] w);
        in_valid[d] = 1'b1;
        act[d]      = a;
        wgt[d]      = w;
        tick();
        in_valid[d] = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            act[i]  = '0;
            wgt[i]  = '0;
            bias[i] = '0;
        end

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_busy",      32'(busy[0]),      32'd0);
        check("rst_acc_out",   acc_out[0],        32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(in_ready[0]),  32'd1);

        // VEC_LEN=4, bias 10, act 1..4, wgt 1 -> 20; bias change after beat 1 ignored
        bias[0] = 32'sd10;
        beat(0, 8'sd1, 8'sd1);
        bias[0] = 32'sd999;
        check("v4_busy_after_b1", 32'(busy[0]), 32'd1);
        beat(0, 8'sd2, 8'sd1);
        beat(0, 8'sd3, 8'sd1);
        check("v4_no_valid_b3", 32'(out_valid[0]), 32'd0);
        beat(0, 8'sd4, 8'sd1);
        check("v4_out_valid",  32'(out_valid[0]), 32'd1);
        check("v4_acc_out",    acc_out[0],        32'd20);
        check("v4_in_ready_0", 32'(in_ready[0]),  32'd0);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("v4_done_valid", 32'(out_valid[0]), 32'd0);
        check("v4_done_busy",  32'(busy[0]),      32'd0);
        check("v4_done_ready", 32'(in_ready[0]),  32'd1);

        // VEC_LEN=2, extreme negative operands -> 16384 - 16256 = 128
        bias[1] = 32'sd0;
        beat(1, -8'sd128, -8'sd128);
        beat(1, -8'sd128, 8'sd127);
        check("v2_neg_valid", 32'(out_valid[1]), 32'd1);
        check("v2_neg_acc",   acc_out[1],        32'd128);
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;

        // VEC_LEN=2, overflow near +max: wrap or saturate depending on build
        bias[1] = 32'sh7FFF_FFF0;
        beat(1, 8'sd127, 8'sd127);
        beat(1, 8'sd127, 8'sd127);
`ifdef MAC_ACCUMULATOR_SAT_EN
        check("v2_ovf_acc", acc_out[1], 32'h7FFF_FFFF);
`else
        check("v2_ovf_acc", acc_out[1], 32'h8000_7DF2);
`endif
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;

        // VEC_LEN=3 with bubbles: -100 + 10 - 12 - 7 = -109
        bias[2] = -32'sd100;
        beat(2, 8'sd5, 8'sd2);
        act[2] = 8'sd99;
        tick();
        beat(2, -8'sd3, 8'sd4);
        act[2] = 8'sd99;
        tick();
        check("v3_mid_valid", 32'(out_valid[2]), 32'd0);
        beat(2, 8'sd7, -8'sd1);
        check("v3_valid", 32'(out_valid[2]), 32'd1);
        // Hold with back-pressure while upstream keeps offering beats
        for (int c = 0; c < 5; c++) begin
            in_valid[2] = 1'b1;
            act[2]      = 8'sd50;
            wgt[2]      = 8'sd50;
            check("v3_hold_acc",   acc_out[2],        -32'sd109);
            check("v3_hold_ready", 32'(in_ready[2]),  32'd0);
            check("v3_hold_valid", 32'(out_valid[2]), 32'd1);
            tick();
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b1;
        check("v3_hs_ready", 32'(in_ready[2]), 32'd0);
        tick();
        out_ready[2] = 1'b0;
        check("v3_after_valid", 32'(out_valid[2]), 32'd0);
        check("v3_after_ready", 32'(in_ready[2]),  32'd1);
        // Next vector: 1 + 1 + 1 + 1 = 4 proves no HOLD beat was consumed
        bias[2] = 32'sd1;
        beat(2, 8'sd1, 8'sd1);
        beat(2, 8'sd1, 8'sd1);
        check("v3_next_early", 32'(out_valid[2]), 32'd0);
        beat(2, 8'sd1, 8'sd1);
        check("v3_next_valid", 32'(out_valid[2]), 32'd1);
        check("v3_next_acc",   acc_out[2],        32'd4);
        out_ready[2] = 1'b1;
        tick();
        out_ready[2] = 1'b0;

        // Reset mid-vector on VEC_LEN=4 discards the partial sum
        bias[0] = 32'sd77;
        beat(0, 8'sd9, 8'sd9);
        beat(0, 8'sd9, 8'sd9);
        rst_n = 1'b0;
        #2;
        check("rstmid_valid", 32'(out_valid[0]), 32'd0);
        check("rstmid_busy",  32'(busy[0]),      32'd0);
        check("rstmid_acc",   acc_out[0],        32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bias[0] = 32'sd0;
        for (int i = 0; i < 4; i++) begin
            beat(0, 8'sd1, 8'sd2);
        end
        check("rstmid_new_valid", 32'(out_valid[0]), 32'd1);
        check("rstmid_new_acc",   acc_out[0],        32'd8);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // VEC_LEN=1 with out_ready tied high: a result every two cycles
        out_ready[3] = 1'b1;
        bias[3] = 32'sd5;
        in_valid[3] = 1'b1; act[3] = 8'sd3; wgt[3] = 8'sd4;
        tick();
        check("v1_a_valid", 32'(out_valid[3]), 32'd1);
        check("v1_a_acc",   acc_out[3],        32'd17);
        bias[3] = -32'sd1; act[3] = -8'sd7; wgt[3] = 8'sd9;
        tick();
        check("v1_a_idle", 32'(out_valid[3]), 32'd0);
        tick();
        check("v1_b_valid", 32'(out_valid[3]), 32'd1);
        check("v1_b_acc",   acc_out[3],        -32'sd64);
        bias[3] = 32'sd0; act[3] = 8'sd127; wgt[3] = -8'sd128;
        tick();
        check("v1_b_idle", 32'(in_ready[3]), 32'd1);
        tick();
        check("v1_c_valid", 32'(out_valid[3]), 32'd1);
        check("v1_c_acc",   acc_out[3],        -32'sd16256);
        in_valid[3] = 1'b0;
        tick();
        check("v1_c_idle", 32'(busy[3]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
